// File: rtl/fifo_rd_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the FIFO read-side packer.
//   DEFAULT_DATASIZE : default FIFO read-data width in bits
//   DEFAULT_PACK     : default number of FIFO entries packed per output word
//   rdState_t        : packer FSM states (FILL = popping, HOLD = presenting)
// Related build macro: FIFO_RD_SEQCHECK_EN (see fifo_rd_packer).
// ----------------------------------------------------------------------------
package fifo_rd_pkg;

   localparam int DEFAULT_DATASIZE = 8;
   localparam int DEFAULT_PACK     = 4;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } rdState_t;

endpackage

// File: rtl/fifo_rd_seqcheck.sv
// ----------------------------------------------------------------------------
// fifo_rd_seqcheck
// Watches every entry popped from the FIFO and counts entries that break an
// incrementing sequence. Only instantiated when FIFO_RD_SEQCHECK_EN is defined.
// Ports:
//   rclk    : read-domain clock (rising edge)
//   rrst    : synchronous active-high reset
//   pop     : an entry is consumed this cycle
//   rdata   : value of the entry being consumed
//   err_cnt : saturating count of sequence errors
// ----------------------------------------------------------------------------
module fifo_rd_seqcheck
   import fifo_rd_pkg::*;
#(
   parameter int DATASIZE = DEFAULT_DATASIZE
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic                pop,
   input  logic [DATASIZE-1:0] rdata,
   output logic [15:0]         err_cnt
);

   logic [DATASIZE-1:0] r_expected;
   logic [15:0]         r_errCnt;

   // The expected value advances by one per pop and wraps naturally at the
   // data width. On a mismatch we resync to the observed value so that one
   // dropped or corrupted entry is counted once rather than forever after.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_expected <= '0;
         r_errCnt   <= '0;
      end else if (pop) begin
         if (rdata != r_expected) begin
            if (r_errCnt != 16'hFFFF) begin
               r_errCnt <= r_errCnt + 16'd1;
            end
            r_expected <= rdata + 1'b1;
         end else begin
            r_expected <= r_expected + 1'b1;
         end
      end
   end

   assign err_cnt = r_errCnt;

endmodule

// File: rtl/fifo_rd_packer.sv
// ----------------------------------------------------------------------------
// fifo_rd_packer
// Pops entries from a FIFO read port and packs PACK of them into one wide
// word (entry 0 in the LSBs). A flush emits a partially filled word. While a
// word is presented nothing is popped, so no entry is lost or duplicated.
// Ports:
//   rclk      : read-domain clock, all logic on the rising edge
//   rrst      : synchronous active-high reset
//   rempty    : FIFO empty flag
//   rdata     : FIFO head entry, valid when rempty=0
//   rinc      : pop strobe to the FIFO
//   flush     : request to emit a partially filled word
//   out_data  : packed word, unfilled lanes read zero
//   out_count : number of valid entries in out_data
//   out_valid : out_data/out_count valid
//   out_ready : consumer accepts the word when out_valid=1
//   err_cnt   : sequence-error count (zero unless FIFO_RD_SEQCHECK_EN)
// Build macro: FIFO_RD_SEQCHECK_EN instantiates the sequence checker.
// ----------------------------------------------------------------------------
module fifo_rd_packer
   import fifo_rd_pkg::*;
#(
   parameter int DATASIZE = DEFAULT_DATASIZE,
   parameter int PACK     = DEFAULT_PACK
) (
   input  logic                       rclk,
   input  logic                       rrst,
   input  logic                       rempty,
   input  logic [DATASIZE-1:0]        rdata,
   output logic                       rinc,
   input  logic                       flush,
   output logic [DATASIZE*PACK-1:0]   out_data,
   output logic [$clog2(PACK+1)-1:0]  out_count,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                err_cnt
);

   localparam int IDXW = $clog2(PACK);
   localparam int CNTW = $clog2(PACK+1);

   rdState_t                 r_state;
   rdState_t                 w_nextState;
   logic [IDXW-1:0]          r_idx;
   logic [DATASIZE*PACK-1:0] r_outData;
   logic [CNTW-1:0]          r_outCount;
   logic                     r_outValid;
   logic                     w_pop;
   logic                     w_lastLane;
   logic                     w_emit;
   logic [CNTW-1:0]          w_count;

   // A word is closed either when the last lane is written or when a flush
   // arrives. A flush with nothing collected and nothing arriving is ignored,
   // so an empty word is never presented.
   always_comb begin
      w_pop      = rinc;
      w_lastLane = (r_idx == IDXW'(PACK-1));
      w_emit     = (w_pop && (w_lastLane || flush)) ||
                   (!w_pop && flush && (r_idx != '0));
      w_count    = w_pop ? (CNTW'(r_idx) + 1'b1) : CNTW'(r_idx);
   end

   // State register.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: FILL until a word closes, HOLD until it is accepted.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         FILL:    if (w_emit)    w_nextState = HOLD;
         HOLD:    if (out_ready) w_nextState = FILL;
         default: w_nextState = FILL;
      endcase
   end

   // Output logic: the pop strobe follows the empty flag combinationally in
   // FILL and is forced low in HOLD and during reset.
   always_comb begin
      rinc = 1'b0;
      if (!rrst && (r_state == FILL)) begin
         rinc = !rempty;
      end
   end

   // Datapath: each pop writes its lane; closing a word raises out_valid and
   // latches the count; acceptance clears everything so the next word starts
   // at lane 0 with zeroed lanes. The index is cleared when the word closes
   // since nothing is popped while the word is held.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_idx      <= '0;
         r_outData  <= '0;
         r_outCount <= '0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_pop) begin
                  r_outData[r_idx*DATASIZE +: DATASIZE] <= rdata;
                  r_idx <= r_idx + 1'b1;
               end
               if (w_emit) begin
                  r_outValid <= 1'b1;
                  r_outCount <= w_count;
                  r_idx      <= '0;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_outData  <= '0;
                  r_outCount <= '0;
                  r_outValid <= 1'b0;
                  r_idx      <= '0;
               end
            end
            default: begin
               r_idx <= '0;
            end
         endcase
      end
   end

   assign out_data  = r_outData;
   assign out_count = r_outCount;
   assign out_valid = r_outValid;

`ifdef FIFO_RD_SEQCHECK_EN
   fifo_rd_seqcheck #(
      .DATASIZE(DATASIZE)
   ) u_seqCheck (
      .rclk    (rclk),
      .rrst    (rrst),
      .pop     (w_pop),
      .rdata   (rdata),
      .err_cnt (err_cnt)
   );
`else
   assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Self-checking bench for fifo_rd_packer. The FIFO is a queue inside the
// bench; a behavioural model tracks which entries have been collected into
// the current word and whether that word is being presented.
// Honours FIFO_RD_SEQCHECK_EN for the expected err_cnt.
// ----------------------------------------------------------------------------
module tb_fifo_rd_packer;

   localparam int DW = 8;
   localparam int PK = 4;

   logic              rclk;
   logic              rrst;
   logic              rempty;
   logic [DW-1:0]     rdata;
   logic              rinc;
   logic              flush;
   logic [DW*PK-1:0]  out_data;
   logic [2:0]        out_count;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       err_cnt;

   int checkCount = 0;
   int errorCount = 0;

   logic [DW-1:0]    fifoQ[$];
   logic [DW-1:0]    mCollected[$];
   bit               mHold = 1'b0;
   logic [DW-1:0]    mExpSeq = '0;
   logic [15:0]      mErr = '0;
   logic [DW*PK-1:0] capData[$];
   logic [2:0]       capCount[$];

   fifo_rd_packer #(
      .DATASIZE(DW),
      .PACK(PK)
   ) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .flush     (flush),
      .out_data  (out_data),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_cnt   (err_cnt)
   );

   // Free-running read clock.
   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic doCheck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW*PK-1:0] packWord();
      logic [DW*PK-1:0] w;
      w = '0;
      for (int i = 0; i < mCollected.size(); i++) begin
         w[i*DW +: DW] = mCollected[i];
      end
      return w;
   endfunction

   function automatic logic [15:0] expErr();
`ifdef FIFO_RD_SEQCHECK_EN
      return mErr;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic checkOutput();
      bit expRinc;
      expRinc = !mHold && (fifoQ.size() > 0) && !rrst;
      doCheck("rinc", rinc, expRinc);
      doCheck("out_valid", out_valid, mHold);
      doCheck("out_data", out_data, packWord());
      if (mHold) doCheck("out_count", out_count, mCollected.size());
      doCheck("err_cnt", err_cnt, expErr());
   endtask

   task automatic modelUpdate(input bit iFlush, input bit iReady, input bit iRst);
      bit pop;
      logic [DW-1:0] v;
      pop = !mHold && (fifoQ.size() > 0) && !iRst;
      if (iRst) begin
         mHold = 1'b0;
         mCollected.delete();
         mExpSeq = '0;
         mErr = '0;
      end else if (mHold) begin
         if (iReady) begin
            mHold = 1'b0;
            mCollected.delete();
         end
      end else if (pop) begin
         v = fifoQ.pop_front();
         if (v != mExpSeq) begin
            if (mErr != 16'hFFFF) mErr = mErr + 16'd1;
         end
         mExpSeq = v + 1'b1;
         mCollected.push_back(v);
         if (mCollected.size() == PK || iFlush) mHold = 1'b1;
      end else if (iFlush && mCollected.size() > 0) begin
         mHold = 1'b1;
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, compare against the
   // model, then advance the model to what the next rising edge will do.
   task automatic applyStimulus(input bit iFlush, input bit iReady, input bit iRst);
      @(negedge rclk);
      flush     = iFlush;
      out_ready = iReady;
      rrst      = iRst;
      rempty    = (fifoQ.size() == 0);
      rdata     = (fifoQ.size() > 0) ? fifoQ[0] : DW'($urandom);
      #1;
      checkOutput();
      if (out_valid === 1'b1 && iReady) begin
         capData.push_back(out_data);
         capCount.push_back(out_count);
      end
      modelUpdate(iFlush, iReady, iRst);
   endtask

   task automatic peek();
      @(posedge rclk);
      #1;
   endtask

   task automatic pushRange(input int first, input int last);
      for (int v = first; v <= last; v++) fifoQ.push_back(DW'(v));
   endtask

   initial begin
      logic [DW-1:0] seqVal;
      rrst = 1'b1; flush = 1'b0; out_ready = 1'b0; rempty = 1'b1; rdata = '0;

      $display("[TB] reset with a non-empty FIFO");
      fifoQ.push_back(8'hAA);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
      peek();
      doCheck("rst_out_count", out_count, 0);
      doCheck("rst_rinc", rinc, 0);
      fifoQ.delete();

      $display("[TB] eight entries, consumer always ready");
      pushRange(0, 7);
      capData.delete(); capCount.delete();
      repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
      doCheck("full_words", capData.size(), 2);
      doCheck("full_word0", capData[0], 32'h03020100);
      doCheck("full_word1", capData[1], 32'h07060504);
      doCheck("full_count0", capCount[0], 4);
      doCheck("full_count1", capCount[1], 4);
      doCheck("full_err", err_cnt, 0);

      $display("[TB] partial word closed by flush");
      pushRange(0, 2);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      peek();
      doCheck("flush_data", out_data, 32'h00020100);
      doCheck("flush_count", out_count, 3);
      doCheck("flush_valid", out_valid, 1);
      pushRange(3, 8);
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] consumer stalls for ten cycles");
      for (int i = 0; i < 10; i++) applyStimulus(i[0], 1'b0, 1'b0);
      capData.delete(); capCount.delete();
      applyStimulus(1'b0, 1'b1, 1'b0);
      doCheck("stall_word", capData[0], 32'h06050403);
      doCheck("stall_count", capCount[0], 4);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] flush together with the second pop");
      pushRange(0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      peek();
      doCheck("cflush_count", out_count, 2);
      doCheck("cflush_data", out_data, 32'h00000100);
      applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] reset while holding a word");
      pushRange(16, 20);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      peek();
      doCheck("hrst_valid", out_valid, 0);
      doCheck("hrst_rinc", rinc, 0);
      pushRange(32, 34);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      peek();
      doCheck("hrst_next_word", out_data, 32'h22212014);
      doCheck("hrst_next_count", out_count, 4);
      applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] broken sequence");
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
      fifoQ.push_back(8'h00); fifoQ.push_back(8'h01);
      fifoQ.push_back(8'h05); fifoQ.push_back(8'h06);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      peek();
`ifdef FIFO_RD_SEQCHECK_EN
      doCheck("seq_err", err_cnt, 1);
`else
      doCheck("seq_err", err_cnt, 0);
`endif
      applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] randomized traffic");
      applyStimulus(1'b0, 1'b0, 1'b1);
      seqVal = '0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) != 0 && fifoQ.size() < 8) begin
            if ($urandom_range(0, 9) == 0) begin
               fifoQ.push_back(DW'($urandom));
            end else begin
               fifoQ.push_back(seqVal);
               seqVal = seqVal + 1'b1;
            end
         end
         applyStimulus($urandom_range(0, 5) == 0,
                       $urandom_range(0, 2) != 0,
                       $urandom_range(0, 99) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, FIFO read-data width in bits.
REQ-002 SHALL have parameter PACK, default 4, FIFO entries packed per output word (2..16).
REQ-003 SHALL have port rclk  input  1  read-domain clock; all logic on its rising edge.
REQ-004 SHALL have port rrst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rempty  input  1  FIFO empty flag.
REQ-006 SHALL have port rdata  input  DATASIZE  FIFO head entry, valid whenever rempty=0.
REQ-007 SHALL have port rinc  output  1  pop strobe; one entry consumed per rclk cycle with rinc=1.
REQ-008 SHALL have port flush  input  1  request to emit a partially filled word.
REQ-009 SHALL have port out_data  output  DATASIZE*PACK  packed word; entry 0 in the LSBs.
REQ-010 SHALL have port out_count  output  $clog2(PACK+1)  number of valid entries in out_data (1..PACK).
REQ-011 SHALL have port out_valid  output  1  out_data/out_count valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
REQ-013 SHALL have port err_cnt  output  16  sequence-error count (see Configuration).

Function
REQ-014 SHALL implement a two-state FSM: FILL (popping from the FIFO), HOLD (presenting a word).
REQ-015 In FILL, rinc SHALL equal !rempty (combinational); in HOLD and during rrst, rinc SHALL be 0.
REQ-016 On each pop, rdata SHALL be written to lane idx of out_data; idx SHALL increment; idx range 0..PACK-1.
REQ-017 A pop at idx=PACK-1 SHALL move FILL->HOLD on the next edge, with out_count=PACK and out_valid=1.
REQ-018 flush=1 in FILL with no pop and idx>0 SHALL move to HOLD with out_count=idx.
REQ-019 flush=1 in the same cycle as a pop SHALL include the popped entry: out_count=idx+1, then HOLD.
REQ-020 flush=1 with idx=0 and no pop SHALL be ignored.
REQ-021 Unfilled lanes of out_data SHALL read 0.
REQ-022 In HOLD, out_data, out_count and out_valid SHALL be held stable until out_ready=1; a later flush SHALL have no effect.
REQ-023 A HOLD handshake SHALL return the FSM to FILL, set idx=0, clear out_data and drop out_valid on the next edge.
REQ-024 Popping SHALL resume the cycle after the handshake; worst-case throughput SHALL be one word per PACK+1 cycles.
REQ-025 No entry SHALL be popped while out_valid=1; no entry SHALL be lost or duplicated.

Reset
REQ-026 While rrst=1: state=FILL, idx=0, out_data=0, out_count=0, out_valid=0, err_cnt=0, rinc=0.
REQ-027 Reset during FILL or HOLD SHALL discard the partial or held word; entries already popped SHALL not be replayed.

Configuration
REQ-028 Macro FIFO_RD_SEQCHECK_EN defined: each popped entry SHALL be compared with an expected value.
REQ-029 The expected value SHALL start at 0 after reset and increment modulo 2^DATASIZE per pop.
REQ-030 On a mismatch, err_cnt SHALL increment, saturating at 16'hFFFF, and expected SHALL resync to rdata+1.
REQ-031 Macro undefined: err_cnt SHALL be tied to 0 and no checker logic SHALL be instantiated.

Structure
REQ-032 Package fifo_rd_pkg SHALL hold the FSM state enum (FILL, HOLD) and the default DATASIZE/PACK constants.
REQ-033 The sequence checker SHALL be a sub-module fifo_rd_seqcheck (inputs rclk, rrst, pop, rdata; output err_cnt), instantiated only under FIFO_RD_SEQCHECK_EN.

Verification
REQ-034 FIFO holds 0x00..0x07, out_ready=1 -> two words, 0x03020100 then 0x07060504, out_count=4, err_cnt=0.
REQ-035 FIFO holds 0x00..0x02, then empty, flush pulsed -> word 0x00020100, out_count=3; popping resumes after handshake.
REQ-036 out_ready=0 for 10 cycles with a full word pending -> rinc=0 and outputs stable throughout; word accepted on the first out_ready=1 cycle.
REQ-037 flush coincident with the 2nd pop (0x00, 0x01) -> out_count=2, out_data=0x00000100.
REQ-038 rrst asserted in HOLD -> out_valid=0 and rinc=0 next cycle; the following word starts at lane 0.
REQ-039 With FIFO_RD_SEQCHECK_EN, stream 0x00, 0x01, 0x05, 0x06 -> err_cnt=1; without the macro, err_cnt=0.
